// File: rtl/uart_rx_param.sv
// uart_rx_param: LSB-first UART receiver, DATA_BITS/STOP_BITS configurable; parity check built only with `define UART_RX_PARITY_EN.
// Latency: valid rises 3 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT cycles after the rx falling edge.
// Backpressure: one output register; a word completing while valid && !ready is dropped and flagged on overrun.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_rx_param: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   stop_bad;
    logic                   par_err_q;
    logic                   tick_half;
    logic                   tick_bit;
    logic                   stop_done;
    logic                   commit;
    logic                   frame_fire;
    logic                   par_fire;

    // rx is asynchronous; nothing downstream looks at it before two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign tick_half = (cnt == HALF_END);
    assign tick_bit  = (cnt == BIT_END);
    assign stop_done = (state == STOP) && tick_bit && (bit_idx == STOP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (!rx_s) state_nxt = START;
            START:  if (tick_half) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (tick_bit && bit_idx == DATA_LAST) state_nxt = PARITY;
            PARITY: if (tick_bit) state_nxt = STOP;
`else
            DATA:   if (tick_bit && bit_idx == DATA_LAST) state_nxt = STOP;
`endif
            // Leaving at the mid-stop sample lets an immediately following start bit be caught.
            STOP:   if (stop_done) state_nxt = rx_s ? IDLE : BREAK;
            BREAK:  if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Framing outranks parity, so a frame reports at most one error.
    always_comb begin
        busy       = (state != IDLE);
        commit     = 1'b0;
        frame_fire = 1'b0;
        par_fire   = 1'b0;
        if (stop_done) begin
            if (stop_bad || !rx_s) begin
                frame_fire = 1'b1;
            end else if (par_err_q) begin
                par_fire = 1'b1;
            end else begin
                commit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            stop_bad  <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_bad <= 1'b0;
                end
                START: begin
                    if (tick_half) cnt <= '0;
                end
                DATA: begin
                    if (tick_bit) begin
                        cnt       <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_idx   <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_bit) cnt <= '0;
                end
`endif
                STOP: begin
                    if (tick_bit) begin
                        cnt      <= '0;
                        bit_idx  <= bit_idx + 1'b1;
                        stop_bad <= stop_bad | ~rx_s;
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    // XOR over data plus parity bit must equal PARITY_ODD.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            par_err_q <= 1'b0;
        end else if (state == PARITY && tick_bit) begin
            par_err_q <= ((^shift_reg) ^ rx_s) != 1'(PARITY_ODD);
        end
    end
`else
    assign par_err_q = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_fire;
            parity_err <= par_fire;
            overrun    <= 1'b0;
            if (commit) begin
                if (!valid || ready) begin
                    data_out <= shift_reg;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param at CLKS_PER_BIT=16, DATA_BITS=8, STOP_BITS=1.
module tb_uart_rx_param;

    localparam int CPB = 16;
    localparam int DB  = 8;
    localparam int SB  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx;
    logic          ready;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int ov_cnt  = 0;
    int vhi_cnt = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    int busy_rise_cyc = 0;
    int ov_cyc = 0;
    bit valid_d = 1'b0;
    bit busy_d  = 1'b0;
    bit busy_seen = 1'b0;
    logic [DB-1:0] exp_q[$];
    logic [DB-1:0] exp_w;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: counts pulses and pops the scoreboard on every accepted word.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
        if (overrun === 1'b1) begin
            ov_cnt++;
            ov_cyc = cyc;
        end
        if (valid === 1'b1) vhi_cnt++;
        if (valid === 1'b1 && !valid_d) rise_cyc = cyc;
        if (busy === 1'b1 && !busy_d) busy_rise_cyc = cyc;
        if (busy === 1'b1) busy_seen = 1'b1;
        valid_d = (valid === 1'b1);
        busy_d  = (busy === 1'b1);
        if (valid === 1'b1 && ready === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL word_unexpected: got %h, expected no word", data_out);
            end else begin
                exp_w = exp_q.pop_front();
                if (data_out !== exp_w) begin
                    n_fail++;
                    $display("FAIL word_data: got %h, expected %h", data_out, exp_w);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input bit par_en, input logic par_b);
        @(posedge clk);
        #1 rx = 1'b0;
        fall_cyc = cyc;
        repeat (CPB - 1) @(posedge clk);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (par_en) send_bit(par_b);
        for (int i = 0; i < SB; i++) send_bit(stop_b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", valid); end
        n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", data_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        n_tests++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b, expected 0", parity_err); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_basic_frame();
        int fe0, pe0, ov0, vh0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (rise_cyc - fall_cyc !== 155) begin n_fail++; $display("FAIL basic_latency: got %0d, expected 155", rise_cyc - fall_cyc); end
        n_tests++; if (busy_rise_cyc - fall_cyc !== 3) begin n_fail++; $display("FAIL basic_busy_delay: got %0d, expected 3", busy_rise_cyc - fall_cyc); end
        n_tests++; if (vhi_cnt - vh0 !== 1) begin n_fail++; $display("FAIL basic_valid_width: got %0d, expected 1", vhi_cnt - vh0); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL basic_word_missing: got %0d pending, expected 0", exp_q.size()); end
        n_tests++; if (fe_cnt + pe_cnt + ov_cnt !== fe0 + pe0 + ov0) begin n_fail++; $display("FAIL basic_flags: got %0d pulses, expected 0", fe_cnt + pe_cnt + ov_cnt - fe0 - pe0 - ov0); end
    endtask

    task automatic test_glitch();
        int fe0, pe0, ov0, vh0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
        busy_seen = 1'b0;
        @(posedge clk);
        #1 rx = 1'b0;
        fall_cyc = cyc;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_tests++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: got %b, expected 1", busy_seen); end
        n_tests++; if (busy_rise_cyc - fall_cyc !== 3) begin n_fail++; $display("FAIL glitch_busy_delay: got %0d, expected 3", busy_rise_cyc - fall_cyc); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle: got %b, expected 0", busy); end
        n_tests++; if (vhi_cnt !== vh0) begin n_fail++; $display("FAIL glitch_valid: got %0d cycles, expected 0", vhi_cnt - vh0); end
        n_tests++; if (fe_cnt + pe_cnt + ov_cnt !== fe0 + pe0 + ov0) begin n_fail++; $display("FAIL glitch_flags: got %0d pulses, expected 0", fe_cnt + pe_cnt + ov_cnt - fe0 - pe0 - ov0); end
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL glitch_next_word: got %0d pending, expected 0", exp_q.size()); end
    endtask

    task automatic test_framing();
        int fe0, pe0, ov0, vh0;
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (40) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL framing_pulse: got %0d, expected 1", fe_cnt - fe0); end
        n_tests++; if (vhi_cnt !== vh0) begin n_fail++; $display("FAIL framing_valid: got %0d cycles, expected 0", vhi_cnt - vh0); end
        n_tests++; if (pe_cnt + ov_cnt !== pe0 + ov0) begin n_fail++; $display("FAIL framing_other_flags: got %0d, expected 0", pe_cnt + ov_cnt - pe0 - ov0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_break_exit: got busy %b, expected 0", busy); end
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL framing_next_word: got %0d pending, expected 0", exp_q.size()); end
        n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL framing_extra_pulse: got %0d, expected 1", fe_cnt - fe0); end
    endtask

    task automatic test_back_to_back();
        int fe0, ov0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        @(posedge clk);
        #1 ready = 1'b0;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_tests++; if (valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid_held: got %b, expected 1", valid); end
        n_tests++; if (data_out !== 8'h01) begin n_fail++; $display("FAIL overrun_data_held: got %h, expected 01", data_out); end
        n_tests++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d, expected 1", ov_cnt - ov0); end
        n_tests++; if (ov_cyc - fall_cyc !== 155) begin n_fail++; $display("FAIL overrun_timing: got %0d, expected 155", ov_cyc - fall_cyc); end
        @(posedge clk);
        #1 ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL overrun_valid_drop: got %b, expected 0", valid); end
        n_tests++; if (data_out !== 8'h01) begin n_fail++; $display("FAIL overrun_data_after: got %h, expected 01", data_out); end
        n_tests++; if (exp_q.size() !== 0 || fe_cnt !== fe0) begin n_fail++; $display("FAIL overrun_drain: got %0d pending %0d frame errs, expected 0 0", exp_q.size(), fe_cnt - fe0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int pe0, fe0, vh0;
        pe0 = pe_cnt; fe0 = fe_cnt; vh0 = vhi_cnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (pe_cnt - pe0 !== 1) begin n_fail++; $display("FAIL parity_pulse: got %0d, expected 1", pe_cnt - pe0); end
        n_tests++; if (vhi_cnt !== vh0) begin n_fail++; $display("FAIL parity_valid: got %0d cycles, expected 0", vhi_cnt - vh0); end
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL parity_good_word: got %0d pending, expected 0", exp_q.size()); end
        n_tests++; if (rise_cyc - fall_cyc !== 171) begin n_fail++; $display("FAIL parity_latency: got %0d, expected 171", rise_cyc - fall_cyc); end
        n_tests++; if (pe_cnt - pe0 !== 1 || fe_cnt !== fe0) begin n_fail++; $display("FAIL parity_flags: got pe %0d fe %0d, expected 1 0", pe_cnt - pe0, fe_cnt - fe0); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int fe0, pe0, ov0, vh0;
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (CPB - 1) @(posedge clk);
        #1 rx = 1'b1;
        repeat (40) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h, expected 00", data_out); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
        n_tests++; if ({frame_err, parity_err, overrun} !== 3'b000) begin n_fail++; $display("FAIL rstmid_flags: got %b, expected 000", {frame_err, parity_err, overrun}); end
        fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_tests++; if (fe_cnt + pe_cnt + ov_cnt + vhi_cnt !== fe0 + pe0 + ov0 + vh0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d events, expected 0", fe_cnt + pe_cnt + ov_cnt + vhi_cnt - fe0 - pe0 - ov0 - vh0); end
        exp_q.push_back(8'h80);
        send_frame(8'h80, 1'b1, 1'b0, 1'b0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_next_word: got %0d pending, expected 0", exp_q.size()); end
        n_tests++; if (rise_cyc - fall_cyc !== 155) begin n_fail++; $display("FAIL rstmid_latency: got %0d, expected 155", rise_cyc - fall_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_framing();
        test_back_to_back();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        n_tests++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %0d pending words, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
